feb_jtag_hdr_seq: RTL
=====================

Name: feb_jtag_hdr_seq

Overview:
- Parametrised successor to the fixed-ROM FEB JTAG header generator.
- Replaces the hard-wired TDI/TMS ROMs with a VME-writeable pattern RAM of configurable depth and channel count.
- Adds a per-channel enable mask, a programmable header length, and an explicit start/busy/done handshake.
- Sits between the VME command decoder and the FEB JTAG pins. Shifts a TMS/TDI header (bypass and register selects) into up to NCH front-end boards before the flash data stream takes over.

Parameters:
- NCH, 5, number of FEB JTAG channels (1..8).
- AW, 7, pattern RAM address width; depth = 2**AW entries.
- HDR_LEN_DEF, 118, header length after reset, in slow-clock periods (1..2**AW).

Ports:
- FASTCLK  in  1  system clock.
- clr_jtagsetup  in  1  reset, asynchronous, active-high.
- CLKCNT  in  5  free-running fast-clock phase counter; one slow period = 16 counts.
- START  in  1  one-FASTCLK request to send the header.
- ABORT  in  1  one-FASTCLK request to stop the header immediately.
- CHMASK  in  NCH  per-channel enable; 1 = channel participates.
- LEN_WE  in  1  write strobe for the header length.
- LEN_DIN  in  AW+1  new header length.
- PAT_WE  in  1  pattern RAM write strobe.
- PAT_ADR  in  AW  pattern RAM write address.
- PAT_DIN  in  NCH+1  pattern word; bit 0 = TMS, bits NCH:1 = TDI per channel.
- JTAGEN  out  1  JTAG pins owned by this block.
- TMS  out  1  shared TMS.
- TDI  out  NCH  per-channel TDI.
- TCK  out  NCH  per-channel TCK.
- BUSY  out  1  sequence in progress.
- HDR_DONE  out  1  one-FASTCLK pulse when the header completes.
- WR_REJ  out  1  sticky flag: a write was rejected.
- PAT_DOUT  out  NCH+1  pattern readback (see Optional Feature).

Behaviour:
- **Clock enables**
  - slow_en is registered high when CLKCNT is 0 or 16.
  - tck_hi is registered high when CLKCNT mod 16 is in 8..15.
- **Reset (clr_jtagsetup high)**
  - All outputs = 0, state = IDLE, address counter = 0, length = HDR_LEN_DEF, WR_REJ = 0.
  - Pattern RAM contents are preserved (power-up contents = 0).
- **State machine: IDLE -> ARM -> SHIFT -> DONE -> IDLE**
  - IDLE: START moves to ARM; the current CHMASK is latched into an internal mask register. BUSY = 0, JTAGEN = 0.
  - ARM: waits for slow_en, then enters SHIFT with addr = 0. JTAGEN and BUSY assert on entry to ARM.
  - SHIFT: TMS/TDI come from RAM[addr] and are registered on slow_en. On each slow_en, addr increments. On the slow_en where addr == len-1, the state moves to DONE.
  - DONE: HDR_DONE pulses for exactly one FASTCLK on entry. On the next slow_en, the state returns to IDLE and JTAGEN/BUSY drop.
  - Total JTAGEN time = len+1 slow periods plus the ARM wait (0..15 FASTCLK).
- **Output gating**
  - TCK[i] = tck_hi only in SHIFT and only if mask[i] = 1; otherwise 0.
  - TDI[i] = 0 when mask[i] = 0.
  - Data changes while TCK is low; TCK rises mid-period (count 8).
- **Start and abort**
  - START while BUSY is ignored.
  - START and ABORT in the same cycle: ABORT wins, state stays IDLE.
  - ABORT in ARM/SHIFT/DONE: the next FASTCLK goes to IDLE, all outputs = 0, and no HDR_DONE pulse is issued.
- **Writes**
  - PAT_WE or LEN_WE while BUSY: the write is dropped and WR_REJ sets.
  - WR_REJ clears on an accepted START.
  - LEN_DIN of 0 or greater than 2**AW is rejected (WR_REJ sets, length unchanged).
  - Pattern writes complete in one FASTCLK.
- **Counter width**
  - The address counter is AW bits with no wrap: len = 2**AW ends at addr 2**AW-1.
- **Reset mid-operation**
  - Immediate IDLE with all outputs 0; no HDR_DONE pulse.

Optional Feature:
- Macro: FEB_JTAG_HDR_READBACK_EN.
- When defined: PAT_DOUT = RAM[PAT_ADR], registered, one-FASTCLK latency. Readback is allowed while BUSY and does not set WR_REJ.
- When undefined: PAT_DOUT is tied to 0 and the second read port is not built.

Test Plan:
- Reset, write RAM[0..3] = 0x01,0x3F,0x00,0x21, LEN=4, CHMASK=0x1F, START -> TMS/TDI sequence 1/00000, 1/11111, 0/00000, 1/10000 over 4 slow periods. 4 TCK rising edges per channel, HDR_DONE pulses once, JTAGEN drops 1 slow period later.
- CHMASK=0x05, same pattern -> TCK[1] and TCK[3] toggle; TCK[2], TCK[4], TCK[5] and TDI[2], TDI[4], TDI[5] stay 0 throughout.
- PAT_WE to addr 2 during SHIFT -> RAM[2] unchanged, WR_REJ = 1. Next START clears WR_REJ.
- ABORT at addr 2 of LEN=118 -> next FASTCLK BUSY = 0, JTAGEN = 0, TCK = 0, no HDR_DONE. A subsequent START restarts from addr 0.
- LEN_WE with 0 and with 129 (AW=7) -> both rejected, length stays 118. A default run gives exactly 118 TCK edges.
- clr_jtagsetup pulse mid-SHIFT -> all outputs 0 asynchronously, length = 118, RAM readback (macro defined) still returns the written values.

Source files
------------

// File: rtl/feb_jtag_hdr_seq_if.sv
// feb_jtag_hdr_seq_if -- command/pin bundle of the FEB JTAG header sequencer.
//
// master : VME command side (drives START/ABORT/CHMASK, length and pattern
//          writes, observes status, JTAG pins and pattern readback).
// slave  : the sequencer itself (feb_jtag_hdr_seq).
//
// Signals
//   START, ABORT      one-FASTCLK header start / stop requests
//   CHMASK[NCH]       per-channel participation mask, latched on START
//   LEN_WE, LEN_DIN   header length write (in slow-clock periods)
//   PAT_WE, PAT_ADR,
//   PAT_DIN[NCH+1]    pattern RAM write; bit 0 = TMS, bits NCH:1 = TDI
//   JTAGEN, TMS, TDI, TCK   FEB JTAG pins
//   BUSY, HDR_DONE, WR_REJ  status
//   PAT_DOUT          pattern readback (zero when readback is not built)
interface feb_jtag_hdr_seq_if #(
   parameter int NCH = 5,
   parameter int AW  = 7
);
   logic           START;
   logic           ABORT;
   logic [NCH-1:0] CHMASK;
   logic           LEN_WE;
   logic [AW:0]    LEN_DIN;
   logic           PAT_WE;
   logic [AW-1:0]  PAT_ADR;
   logic [NCH:0]   PAT_DIN;
   logic           JTAGEN;
   logic           TMS;
   logic [NCH-1:0] TDI;
   logic [NCH-1:0] TCK;
   logic           BUSY;
   logic           HDR_DONE;
   logic           WR_REJ;
   logic [NCH:0]   PAT_DOUT;

   modport master (
      output START, ABORT, CHMASK, LEN_WE, LEN_DIN, PAT_WE, PAT_ADR, PAT_DIN,
      input  JTAGEN, TMS, TDI, TCK, BUSY, HDR_DONE, WR_REJ, PAT_DOUT
   );

   modport slave (
      input  START, ABORT, CHMASK, LEN_WE, LEN_DIN, PAT_WE, PAT_ADR, PAT_DIN,
      output JTAGEN, TMS, TDI, TCK, BUSY, HDR_DONE, WR_REJ, PAT_DOUT
   );
endinterface

// File: rtl/feb_jtag_hdr_seq.sv
// feb_jtag_hdr_seq -- programmable FEB JTAG header sequencer.
//
// Shifts a TMS/TDI header, stored in a VME-writeable pattern RAM, into up to
// NCH front-end boards before the flash data stream takes over. Each pattern
// word is presented for one slow-clock period (16 FASTCLK); TCK rises in the
// middle of the period so data always changes while TCK is low.
//
// Ports
//   FASTCLK        system clock
//   clr_jtagsetup  asynchronous active-high reset (pattern RAM is kept)
//   CLKCNT[5]      free-running fast-clock phase counter, 16 counts per slow period
//   bus            feb_jtag_hdr_seq_if.slave: start/abort handshake, length and
//                  pattern writes, JTAG pins, status and pattern readback
//
// Parameters
//   NCH            number of FEB channels (1..8)
//   AW             pattern RAM address width, depth 2**AW
//   HDR_LEN_DEF    header length after reset (1..2**AW)
//
// Build option
//   FEB_JTAG_HDR_READBACK_EN  builds a registered second read port so that
//                             PAT_DOUT = RAM[PAT_ADR] one FASTCLK later;
//                             otherwise PAT_DOUT is tied to 0.
module feb_jtag_hdr_seq #(
   parameter int NCH         = 5,
   parameter int AW          = 7,
   parameter int HDR_LEN_DEF = 118
) (
   input  logic              FASTCLK,
   input  logic              clr_jtagsetup,
   input  logic [4:0]        CLKCNT,
   feb_jtag_hdr_seq_if.slave bus
);

   localparam int            DEPTH   = 2 ** AW;
   localparam logic [AW:0]   LEN_RST = (AW+1)'(HDR_LEN_DEF);
   localparam logic [AW:0]   LEN_MAX = (AW+1)'(DEPTH);
   localparam logic [AW:0]   LEN_ONE = (AW+1)'(1);
   localparam logic [AW-1:0] ADR_ONE = AW'(1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ARM,
      S_SHIFT,
      S_DONE
   } state_t;

   state_t         state;
   state_t         state_nxt;

   logic           slow_en;
   logic           tck_hi;
   logic [AW-1:0]  addr;
   logic [AW:0]    hdr_len;
   logic [NCH-1:0] mask_q;
   logic           tms_q;
   logic [NCH-1:0] tdi_q;
   logic           hdr_done_q;
   logic           wr_rej_q;

   logic [NCH:0]   pat_ram [DEPTH];

   logic           busy;
   logic           last_addr;
   logic           accept_start;
   logic           load_first;
   logic           advance;
   logic           finish;
   logic           len_ok;
   logic           pat_wr_ok;
   logic           len_wr_ok;
   logic           wr_reject;
   logic [AW-1:0]  rd_adr;
   logic [NCH:0]   rd_word;

   // Next-state decode. ABORT has priority over everything, including a
   // simultaneous START in IDLE and the final slow_en of SHIFT, so an aborted
   // header never reaches DONE and never pulses HDR_DONE.
   always_comb begin
      state_nxt    = state;
      accept_start = 1'b0;
      load_first   = 1'b0;
      advance      = 1'b0;
      finish       = 1'b0;
      case (state)
         S_IDLE: begin
            if (bus.START && !bus.ABORT) begin
               state_nxt    = S_ARM;
               accept_start = 1'b1;
            end
         end
         S_ARM: begin
            if (bus.ABORT) begin
               state_nxt = S_IDLE;
            end else if (slow_en) begin
               state_nxt  = S_SHIFT;
               load_first = 1'b1;
            end
         end
         S_SHIFT: begin
            if (bus.ABORT) begin
               state_nxt = S_IDLE;
            end else if (slow_en) begin
               if (last_addr) begin
                  state_nxt = S_DONE;
                  finish    = 1'b1;
               end else begin
                  advance = 1'b1;
               end
            end
         end
         S_DONE: begin
            if (bus.ABORT || slow_en) begin
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Datapath decode. The RAM word for the period about to start is read
   // ahead: RAM[0] when leaving ARM, RAM[addr+1] when SHIFT advances, so the
   // word shown during a SHIFT period always matches addr.
   always_comb begin
      busy      = (state != S_IDLE);
      last_addr = ({1'b0, addr} == (hdr_len - LEN_ONE));
      len_ok    = (bus.LEN_DIN != '0) && (bus.LEN_DIN <= LEN_MAX);
      pat_wr_ok = bus.PAT_WE && !busy;
      len_wr_ok = bus.LEN_WE && !busy && len_ok;
      wr_reject = (bus.PAT_WE && busy) || (bus.LEN_WE && !(len_ok && !busy));
      rd_adr    = load_first ? '0 : (addr + ADR_ONE);
      rd_word   = pat_ram[rd_adr];
   end

   // State register.
   always_ff @(posedge FASTCLK or posedge clr_jtagsetup) begin
      if (clr_jtagsetup) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Clock enables, header length, channel mask, address counter, pin
   // registers and status flags. The pin registers clear whenever the next
   // state is not SHIFT, which covers DONE, ABORT and the idle states.
   // A rejected write in the same cycle as an accepted START still sets WR_REJ.
   always_ff @(posedge FASTCLK or posedge clr_jtagsetup) begin
      if (clr_jtagsetup) begin
         slow_en    <= 1'b0;
         tck_hi     <= 1'b0;
         addr       <= '0;
         hdr_len    <= LEN_RST;
         mask_q     <= '0;
         tms_q      <= 1'b0;
         tdi_q      <= '0;
         hdr_done_q <= 1'b0;
         wr_rej_q   <= 1'b0;
      end else begin
         slow_en    <= (CLKCNT == 5'd0) || (CLKCNT == 5'd16);
         tck_hi     <= CLKCNT[3];
         hdr_done_q <= finish;

         if (len_wr_ok) begin
            hdr_len <= bus.LEN_DIN;
         end

         if (accept_start) begin
            mask_q <= bus.CHMASK;
         end

         if (load_first) begin
            addr  <= '0;
            tms_q <= rd_word[0];
            tdi_q <= rd_word[NCH:1];
         end else if (advance) begin
            addr  <= rd_adr;
            tms_q <= rd_word[0];
            tdi_q <= rd_word[NCH:1];
         end else if (state_nxt != S_SHIFT) begin
            tms_q <= 1'b0;
            tdi_q <= '0;
         end

         if (wr_reject) begin
            wr_rej_q <= 1'b1;
         end else if (accept_start) begin
            wr_rej_q <= 1'b0;
         end
      end
   end

   // Pattern RAM write port. No reset: contents survive clr_jtagsetup.
   always_ff @(posedge FASTCLK) begin
      if (pat_wr_ok) begin
         pat_ram[bus.PAT_ADR] <= bus.PAT_DIN;
      end
   end

`ifdef FEB_JTAG_HDR_READBACK_EN
   logic [NCH:0] pat_dout_q;

   // Registered readback port, usable while a header is running.
   always_ff @(posedge FASTCLK or posedge clr_jtagsetup) begin
      if (clr_jtagsetup) begin
         pat_dout_q <= '0;
      end else begin
         pat_dout_q <= pat_ram[bus.PAT_ADR];
      end
   end

   assign bus.PAT_DOUT = pat_dout_q;
`else
   assign bus.PAT_DOUT = '0;
`endif

   // Pin and status outputs. TCK and TDI are gated by the latched mask so a
   // disabled channel stays completely quiet.
   assign bus.BUSY     = busy;
   assign bus.JTAGEN   = busy;
   assign bus.TMS      = tms_q;
   assign bus.TDI      = tdi_q & mask_q;
   assign bus.TCK      = ((state == S_SHIFT) && tck_hi) ? mask_q : '0;
   assign bus.HDR_DONE = hdr_done_q;
   assign bus.WR_REJ   = wr_rej_q;

endmodule
